// File: rtl/fpdiv_r64_pkg.sv
// rtl/fpdiv_r64_pkg.sv - shared radix-4 divider digit encodings and accumulator FSM states
package fpdiv_r64_pkg;

    // One-hot radix-4 quotient digits as produced by the QDS
    localparam logic [4:0] QUO_DIG_NEG_2 = 5'b10000;
    localparam logic [4:0] QUO_DIG_NEG_1 = 5'b01000;
    localparam logic [4:0] QUO_DIG_ZERO  = 5'b00100;
    localparam logic [4:0] QUO_DIG_POS_1 = 5'b00010;
    localparam logic [4:0] QUO_DIG_POS_2 = 5'b00001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } otfc_state_e;

endpackage

// File: rtl/r4_otfc_step.sv
// rtl/r4_otfc_step.sv - combinational one-digit on-the-fly conversion of Q/QM
import fpdiv_r64_pkg::*;

module r4_otfc_step #(
    parameter int QUO_W = 56
) (
    input  logic [QUO_W-1:0] quo,
    input  logic [QUO_W-1:0] quo_m1,
    input  logic [4:0]       quo_dig,
    output logic [QUO_W-1:0] quo_nxt,
    output logic [QUO_W-1:0] quo_m1_nxt
);

    logic [QUO_W-1:0] quo_sh;
    logic [QUO_W-1:0] quo_m1_sh;

    // Shift both candidates by one radix-4 position; top bits wrap out
    assign quo_sh    = quo << 2;
    assign quo_m1_sh = quo_m1 << 2;

    // Select the new low digit pair and which candidate each result grows from
    always_comb begin
        quo_nxt    = quo_sh;
        quo_m1_nxt = quo_m1_sh | QUO_W'(2'b11);
        case (quo_dig)
            QUO_DIG_POS_2: begin
                quo_nxt    = quo_sh | QUO_W'(2'b10);
                quo_m1_nxt = quo_sh | QUO_W'(2'b01);
            end
            QUO_DIG_POS_1: begin
                quo_nxt    = quo_sh | QUO_W'(2'b01);
                quo_m1_nxt = quo_sh;
            end
            QUO_DIG_ZERO: begin
                quo_nxt    = quo_sh;
                quo_m1_nxt = quo_m1_sh | QUO_W'(2'b11);
            end
            QUO_DIG_NEG_1: begin
                quo_nxt    = quo_m1_sh | QUO_W'(2'b11);
                quo_m1_nxt = quo_m1_sh | QUO_W'(2'b10);
            end
            QUO_DIG_NEG_2: begin
                quo_nxt    = quo_m1_sh | QUO_W'(2'b10);
                quo_m1_nxt = quo_m1_sh | QUO_W'(2'b01);
            end
            default: begin
                // Malformed digit: result is don't-care, treat like zero
                quo_nxt    = quo_sh;
                quo_m1_nxt = quo_m1_sh | QUO_W'(2'b11);
            end
        endcase
    end

endmodule

// File: rtl/r4_otfc_quo_acc.sv
// rtl/r4_otfc_quo_acc.sv - radix-4 OTFC quotient accumulator; optional R4_OTFC_ONEHOT_CHK_EN digit checker
import fpdiv_r64_pkg::*;

module r4_otfc_quo_acc #(
    parameter int QUO_W  = 56,
    parameter int ITER_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid_i,
    output logic              start_ready_o,
    input  logic [ITER_W-1:0] iter_num_i,
    input  logic              flush_i,
    input  logic              dig_valid_i,
    input  logic [4:0]        quo_dig_i,
    output logic [4:0]        prev_quo_dig_o,
    output logic              busy_o,
    output logic              finish_valid_o,
    input  logic              finish_ready_i,
    output logic [QUO_W-1:0]  quo_o,
    output logic [QUO_W-1:0]  quo_m1_o
`ifdef R4_OTFC_ONEHOT_CHK_EN
    ,
    output logic              dig_err_o
`endif
);

    otfc_state_e       state_q;
    otfc_state_e       state_d;
    logic [QUO_W-1:0]  quo_q;
    logic [QUO_W-1:0]  quo_m1_q;
    logic [QUO_W-1:0]  quo_nxt;
    logic [QUO_W-1:0]  quo_m1_nxt;
    logic [4:0]        prev_dig_q;
    logic [ITER_W-1:0] cnt_q;
    logic              start_hs;
    logic              dig_acc;

    assign start_hs = (state_q == ST_IDLE) && start_valid_i;
    assign dig_acc  = (state_q == ST_ITER) && dig_valid_i;

    r4_otfc_step #(
        .QUO_W (QUO_W)
    ) u_step (
        .quo        (quo_q),
        .quo_m1     (quo_m1_q),
        .quo_dig    (quo_dig_i),
        .quo_nxt    (quo_nxt),
        .quo_m1_nxt (quo_m1_nxt)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_valid_i) state_d = ST_ITER;
            ST_ITER: if (dig_valid_i && (cnt_q == ITER_W'(1))) state_d = ST_DONE;
            ST_DONE: if (finish_ready_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) begin
            state_d = ST_IDLE;
        end
    end

    // Q/QM, previous digit and remaining-digit counter
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            quo_q      <= '0;
            quo_m1_q   <= '1;
            prev_dig_q <= QUO_DIG_ZERO;
            cnt_q      <= '0;
        end else if (start_hs) begin
            quo_q      <= '0;
            quo_m1_q   <= '1;
            prev_dig_q <= QUO_DIG_ZERO;
            // A zero count still produces one digit
            cnt_q      <= (iter_num_i == '0) ? ITER_W'(1) : iter_num_i;
        end else if (dig_acc) begin
            quo_q      <= quo_nxt;
            quo_m1_q   <= quo_m1_nxt;
            prev_dig_q <= quo_dig_i;
            cnt_q      <= cnt_q - ITER_W'(1);
        end
    end

    assign start_ready_o  = (state_q == ST_IDLE);
    assign busy_o         = (state_q == ST_ITER);
    assign finish_valid_o = (state_q == ST_DONE);
    assign prev_quo_dig_o = prev_dig_q;
    assign quo_o          = quo_q;
    assign quo_m1_o       = quo_m1_q;

`ifdef R4_OTFC_ONEHOT_CHK_EN
    logic dig_err_q;

    // Sticky flag for any accepted digit that is not one-hot
    always_ff @(posedge clk) begin
        if (rst || flush_i || start_hs) begin
            dig_err_q <= 1'b0;
        end else if (dig_acc && !$onehot(quo_dig_i)) begin
            dig_err_q <= 1'b1;
        end
    end

    assign dig_err_o = dig_err_q;

    a_dig_onehot: assert property (@(posedge clk) disable iff (rst || flush_i)
        dig_acc |-> $onehot(quo_dig_i));
`endif

endmodule
